grf_wb: RTL and testbench
=========================

# grf_wb

General register file on the receiving end of the W-stage writeback path in the 5-stage MIPS pipeline. Accepts the W-stage write request (`RegWrite`, destination, data, PC) and commits it to a 32×32-bit register array. Serves the D-stage's two combinational read ports, with internal write-to-read bypass. Emits a registered one-cycle commit trace plus a retired-write counter for the verification harness.

## Interface
- `INTERNAL_FWD`, default 1: 1 = a read of the register being written this cycle returns the write data; 0 = returns the old array value.
- `TRACE_EN`, default 1: 1 = trace outputs active; 0 = trace outputs held at 0.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low; sampled on the `clk` rising edge.
- `RegWrite_W` in 1: write request from the W-stage controller.
- `A3_W` in 5: destination register number.
- `WD_W` in 32: writeback data, already muxed by MemtoReg/link selection.
- `PC_W` in 32: PC of the instruction in W.
- `A1_D` in 5: read address for rs.
- `A2_D` in 5: read address for rt.
- `RD1_D` out 32: rs data (combinational).
- `RD2_D` out 32: rt data (combinational).
- `trace_valid` out 1: one-cycle pulse per committed write.
- `trace_pc` out 32: PC of the committed write.
- `trace_addr` out 5: register written.
- `trace_data` out 32: value written.
- `wr_count` out 32: number of committed writes since reset.

## Operation
- A write is effective when `RegWrite_W`=1 and `A3_W`≠0. Only effective writes update the array at the clock edge.
- `$0`:
  - Never stored; reads of address 0 return 0 regardless of bypass.
  - `RegWrite_W`=1 with `A3_W`=0 is ignored: no trace pulse, no count.
- Read path:
  - `RDn_D` = 0 if `An_D`=0.
  - Else, if `INTERNAL_FWD`=1, the write is effective and `An_D`=`A3_W`: `RDn_D` = `WD_W`.
  - Otherwise: `RDn_D` = array[`An_D`].
- Both read ports are independent; `A1_D`=`A2_D` is legal and returns identical data.
- Trace: on each effective write, the next cycle shows `trace_valid`=1 with `trace_pc`/`trace_addr`/`trace_data` equal to the committed `PC_W`/`A3_W`/`WD_W`. Otherwise `trace_valid`=0 and the other trace fields hold their last values.
- `wr_count`:
  - Increments by 1 per effective write, registered.
  - Wraps from 0xFFFFFFFF to 0.
  - Independent of `TRACE_EN`.
- Reset:
  - All 31 array entries clear to 0.
  - Trace outputs clear to 0 and `wr_count` clears to 0.
  - Reset dominates any simultaneous write request; that write is dropped and not counted.

## Timing
- Write latency: the array updates at the rising edge where the write is effective.
- Without bypass, a read of the written register reflects the new value from the cycle after that edge.
- With bypass (`INTERNAL_FWD`=1): read-after-write latency is 0, same cycle, combinational `WD_W`→`RDn_D` path.
- Trace latency: exactly 1 cycle after the commit edge; `trace_valid` is high for exactly one cycle per write.
- Back-to-back writes produce consecutive trace pulses with no gaps.
- The same register written on consecutive cycles: each write is traced, and the last write wins in the array.
- Reset outputs: `RD1_D`/`RD2_D` read 0 for every address while the array is cleared. `trace_*`=0 and `wr_count`=0 after the first rising edge with `reset`=0.
- Reset asserted mid-stream: the array clears on that edge; the pending trace of the prior cycle's write is suppressed (trace registers cleared).

## Test plan
- Reset then read: hold `reset`=0 for 2 cycles, release; `A1_D`=5, `A2_D`=31 → `RD1_D`=`RD2_D`=0, `trace_valid`=0, `wr_count`=0.
- Write/read: write $8←0x12345678 (`PC_W`=0x3000); next cycle `A1_D`=8 → `RD1_D`=0x12345678; `trace_valid`=1, `trace_pc`=0x3000, `trace_addr`=8, `wr_count`=1.
- Bypass: same-cycle write $9←0xDEADBEEF with `A1_D`=`A2_D`=9 → both reads 0xDEADBEEF in that cycle. With `INTERNAL_FWD`=0 → both read the old value 0.
- `$0` write: `RegWrite_W`=1, `A3_W`=0, `WD_W`=0xFFFFFFFF → `RD1_D`(A1=0)=0, no trace pulse, `wr_count` unchanged.
- Back-to-back writes: $3←1, $3←2, $4←3 on consecutive cycles → three consecutive trace pulses; then $3 reads 2, $4 reads 3, and `wr_count`=3.
- Reset mid-operation: write $10←7; on the following edge assert `reset`=0 together with a write $11←9 → all reads 0, no trace pulse, `wr_count`=0.

Source files
------------

// File: rtl/grf_wb.sv
// W-stage writeback register file: 32x32 array with $0 hardwired to zero,
// two combinational read ports with optional write bypass, and a commit trace.
module grf_wb #(
    parameter bit INTERNAL_FWD = 1'b1,
    parameter bit TRACE_EN     = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWrite_W,
    input  logic [4:0]  A3_W,
    input  logic [31:0] WD_W,
    input  logic [31:0] PC_W,
    input  logic [4:0]  A1_D,
    input  logic [4:0]  A2_D,
    output logic [31:0] RD1_D,
    output logic [31:0] RD2_D,
    output logic        trace_valid,
    output logic [31:0] trace_pc,
    output logic [4:0]  trace_addr,
    output logic [31:0] trace_data,
    output logic [31:0] wr_count
);

    logic [31:0] r_regs [1:31];
    logic        r_trace_valid;
    logic [31:0] r_trace_pc;
    logic [4:0]  r_trace_addr;
    logic [31:0] r_trace_data;
    logic [31:0] r_wr_count;
    logic        w_we;

    assign w_we = RegWrite_W && (A3_W != 5'd0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 1; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_we) begin
            r_regs[A3_W] <= WD_W;
        end
    end

    // Trace fields only load on a commit so they keep their last value between pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_trace_valid <= 1'b0;
            r_trace_pc    <= '0;
            r_trace_addr  <= '0;
            r_trace_data  <= '0;
        end else begin
            r_trace_valid <= w_we && TRACE_EN;
            if (w_we && TRACE_EN) begin
                r_trace_pc   <= PC_W;
                r_trace_addr <= A3_W;
                r_trace_data <= WD_W;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_count <= '0;
        end else if (w_we) begin
            r_wr_count <= r_wr_count + 32'd1;
        end
    end

    always_comb begin
        RD1_D = '0;
        if (A1_D != 5'd0) begin
            if (INTERNAL_FWD && w_we && (A1_D == A3_W)) begin
                RD1_D = WD_W;
            end else begin
                RD1_D = r_regs[A1_D];
            end
        end
    end

    always_comb begin
        RD2_D = '0;
        if (A2_D != 5'd0) begin
            if (INTERNAL_FWD && w_we && (A2_D == A3_W)) begin
                RD2_D = WD_W;
            end else begin
                RD2_D = r_regs[A2_D];
            end
        end
    end

    assign trace_valid = r_trace_valid;
    assign trace_pc    = r_trace_pc;
    assign trace_addr  = r_trace_addr;
    assign trace_data  = r_trace_data;
    assign wr_count    = r_wr_count;

endmodule

// File: tb/tb_grf_wb.sv
// Bench for grf_wb: one instance with bypass and trace enabled, one with both
// disabled, driven together and compared against an array-based reference model.
module tb_grf_wb;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite_W;
    logic [4:0]  A3_W, A1_D, A2_D;
    logic [31:0] WD_W, PC_W;

    logic [31:0] a_rd1, a_rd2, a_tpc, a_tdata, a_cnt;
    logic        a_tv;
    logic [4:0]  a_taddr;
    logic [31:0] b_rd1, b_rd2, b_tpc, b_tdata, b_cnt;
    logic        b_tv;
    logic [4:0]  b_taddr;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_cnt;
    logic        m_tv;
    logic [31:0] m_tpc, m_tdata;
    logic [4:0]  m_taddr;

    always #5 clk = ~clk;

    grf_wb #(.INTERNAL_FWD(1'b1), .TRACE_EN(1'b1)) dut_a (
        .clk(clk), .reset(reset), .RegWrite_W(RegWrite_W), .A3_W(A3_W),
        .WD_W(WD_W), .PC_W(PC_W), .A1_D(A1_D), .A2_D(A2_D),
        .RD1_D(a_rd1), .RD2_D(a_rd2), .trace_valid(a_tv), .trace_pc(a_tpc),
        .trace_addr(a_taddr), .trace_data(a_tdata), .wr_count(a_cnt)
    );

    grf_wb #(.INTERNAL_FWD(1'b0), .TRACE_EN(1'b0)) dut_b (
        .clk(clk), .reset(reset), .RegWrite_W(RegWrite_W), .A3_W(A3_W),
        .WD_W(WD_W), .PC_W(PC_W), .A1_D(A1_D), .A2_D(A2_D),
        .RD1_D(b_rd1), .RD2_D(b_rd2), .trace_valid(b_tv), .trace_pc(b_tpc),
        .trace_addr(b_taddr), .trace_data(b_tdata), .wr_count(b_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a, input bit fwd,
                                           input bit we, input logic [4:0] a3,
                                           input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
        if (fwd && we && a3 != 5'd0 && a == a3) return wd;
        return m_regs[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_cnt = '0; m_tv = 1'b0; m_tpc = '0; m_taddr = '0; m_tdata = '0;
    endtask

    task automatic check_regs();
        chk("a_tv", {31'd0, a_tv}, {31'd0, m_tv});
        chk("a_tpc", a_tpc, m_tpc);
        chk("a_taddr", {27'd0, a_taddr}, {27'd0, m_taddr});
        chk("a_tdata", a_tdata, m_tdata);
        chk("a_cnt", a_cnt, m_cnt);
        chk("b_tv", {31'd0, b_tv}, 32'd0);
        chk("b_tpc", b_tpc, 32'd0);
        chk("b_taddr", {27'd0, b_taddr}, 32'd0);
        chk("b_tdata", b_tdata, 32'd0);
        chk("b_cnt", b_cnt, m_cnt);
    endtask

    // Starts and ends 1 time unit after a rising edge.
    task automatic step(input bit rst_n, input bit we, input logic [4:0] a3,
                        input logic [31:0] wd, input logic [31:0] pc,
                        input logic [4:0] a1, input logic [4:0] a2);
        reset = rst_n; RegWrite_W = we; A3_W = a3; WD_W = wd; PC_W = pc;
        A1_D = a1; A2_D = a2;
        #2;
        chk("a_rd1", a_rd1, m_read(a1, 1'b1, we, a3, wd));
        chk("a_rd2", a_rd2, m_read(a2, 1'b1, we, a3, wd));
        chk("b_rd1", b_rd1, m_read(a1, 1'b0, we, a3, wd));
        chk("b_rd2", b_rd2, m_read(a2, 1'b0, we, a3, wd));
        @(posedge clk);
        #1;
        if (!rst_n) begin
            model_reset();
        end else if (we && a3 != 5'd0) begin
            m_regs[a3] = wd;
            m_cnt = m_cnt + 32'd1;
            m_tv = 1'b1; m_tpc = pc; m_taddr = a3; m_tdata = wd;
        end else begin
            m_tv = 1'b0;
        end
        check_regs();
    endtask

    initial begin
        reset = 1'b0; RegWrite_W = 1'b0; A3_W = '0; WD_W = '0; PC_W = '0;
        A1_D = '0; A2_D = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_regs();

        // Reset then read
        step(1, 0, 0, 0, 0, 5, 31);
        chk("rst_rd1", a_rd1, 32'd0);
        chk("rst_cnt", a_cnt, 32'd0);

        // Write / read
        step(1, 1, 8, 32'h12345678, 32'h3000, 0, 0);
        chk("wr_tv", {31'd0, a_tv}, 32'd1);
        chk("wr_tpc", a_tpc, 32'h3000);
        chk("wr_taddr", {27'd0, a_taddr}, 32'd8);
        chk("wr_cnt", a_cnt, 32'd1);
        A1_D = 5'd8; RegWrite_W = 1'b0;
        #1;
        chk("wr_rd8", a_rd1, 32'h12345678);
        chk("wr_rd8_b", b_rd1, 32'h12345678);

        // Bypass: dut_a sees new data, dut_b the old zero
        RegWrite_W = 1'b1; A3_W = 5'd9; WD_W = 32'hDEADBEEF; A1_D = 5'd9; A2_D = 5'd9;
        #1;
        chk("byp_a1", a_rd1, 32'hDEADBEEF);
        chk("byp_a2", a_rd2, 32'hDEADBEEF);
        chk("byp_b1", b_rd1, 32'd0);
        chk("byp_b2", b_rd2, 32'd0);
        step(1, 1, 9, 32'hDEADBEEF, 32'h3004, 9, 9);

        // $0 write ignored; trace fields hold
        step(1, 1, 0, 32'hFFFFFFFF, 32'h3008, 0, 0);
        chk("z_rd", a_rd1, 32'd0);
        chk("z_tv", {31'd0, a_tv}, 32'd0);
        chk("z_cnt", a_cnt, 32'd2);
        chk("z_hold", a_tdata, 32'hDEADBEEF);

        // Back-to-back writes
        step(1, 1, 3, 32'd1, 32'h4000, 0, 0);
        step(1, 1, 3, 32'd2, 32'h4004, 3, 3);
        chk("b2b_tv2", {31'd0, a_tv}, 32'd1);
        step(1, 1, 4, 32'd3, 32'h4008, 3, 4);
        chk("b2b_tv3", {31'd0, a_tv}, 32'd1);
        step(1, 0, 0, 0, 0, 3, 4);
        chk("b2b_r3", a_rd1, 32'd2);
        chk("b2b_r4", a_rd2, 32'd3);
        chk("b2b_cnt", a_cnt, 32'd5);

        // Reset mid-operation
        step(1, 1, 10, 32'd7, 32'h5000, 0, 0);
        step(0, 1, 11, 32'd9, 32'h5004, 0, 0);
        chk("mr_tv", {31'd0, a_tv}, 32'd0);
        chk("mr_cnt", a_cnt, 32'd0);
        step(1, 0, 0, 0, 0, 10, 11);
        step(1, 0, 0, 0, 0, 8, 3);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            bit          r_rst, r_we;
            logic [4:0]  r_a3, r_a1, r_a2;
            r_rst = ($urandom_range(0, 39) != 0);
            r_we  = ($urandom_range(0, 3) != 0);
            r_a3  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            r_a1  = ($urandom_range(0, 2) == 0) ? r_a3 : 5'($urandom_range(0, 7));
            r_a2  = ($urandom_range(0, 2) == 0) ? r_a3 : 5'($urandom_range(0, 31));
            step(r_rst, r_we, r_a3, $urandom, $urandom, r_a1, r_a2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
